// File: rtl/key_cond_if.sv
// key_cond_if: raw button inputs and conditioned event outputs of the key conditioner
interface key_cond_if;
   logic [3:0] i_sw;
   logic [3:0] o_level;
   logic [3:0] o_press;
   logic [3:0] o_release;
   logic [3:0] o_long;
   modport master (output i_sw, input o_level, o_press, o_release, o_long);
   modport slave (input i_sw, output o_level, o_press, o_release, o_long);
endinterface

// File: rtl/key_cond.sv
// key_cond: 4-channel push-button conditioner with debounce, long-press and auto-repeat
module key_cond #(
   parameter int         DEB_CYC  = 500000,
   parameter int         LONG_CYC = 50000000,
   parameter int         RPT_CYC  = 10000000,
   parameter logic [3:0] RPT_MASK = 4'b0100
) (
   input logic       clk,
   input logic       rst,
   key_cond_if.slave kb
);
   typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;
   localparam logic [23:0] DEB_MAX  = 24'(DEB_CYC - 1);
   localparam logic [26:0] LONG_MAX = 27'(LONG_CYC - 1);
   localparam logic [26:0] RPT_MAX  = 27'(RPT_CYC - 1);
   logic [3:0]  s1, s2, p, lvl, rise, fall, prs, rel, lng;
   logic [23:0] deb [4];
   logic [26:0] hold [4];
   logic [26:0] rpt [4];
   state_t      st [4];
   assign p = ~s2;
   // two-flop synchronizer, idles at released (1)
   always_ff @(posedge clk)
      if (rst) begin
         s1 <= 4'hf;
         s2 <= 4'hf;
      end else begin
         s1 <= kb.i_sw;
         s2 <= s1;
      end
   // debounced edges: the pressed level has disagreed for a full window
   always_comb begin
      rise = '0;
      fall = '0;
      for (int i = 0; i < 4; i++) begin
         rise[i] = p[i] && !lvl[i] && deb[i] == DEB_MAX;
         fall[i] = !p[i] && lvl[i] && deb[i] == DEB_MAX;
      end
   end
   // debounce counters and debounced level
   always_ff @(posedge clk)
      if (rst) begin
         lvl <= '0;
         for (int i = 0; i < 4; i++) deb[i] <= '0;
      end else begin
         lvl <= lvl ^ rise ^ fall;
         for (int i = 0; i < 4; i++)
            deb[i] <= (p[i] == lvl[i] || deb[i] == DEB_MAX) ? '0 : deb[i] + 24'd1;
      end
   // per-channel press/long/repeat FSM; release has priority and cancels pending pulses
   always_ff @(posedge clk)
      for (int i = 0; i < 4; i++)
         if (rst) begin
            st[i]   <= IDLE;
            hold[i] <= '0;
            rpt[i]  <= '0;
            prs[i]  <= 1'b0;
            rel[i]  <= 1'b0;
            lng[i]  <= 1'b0;
         end else begin
            prs[i] <= 1'b0;
            rel[i] <= 1'b0;
            lng[i] <= 1'b0;
            if (fall[i]) begin
               st[i]   <= IDLE;
               hold[i] <= '0;
               rpt[i]  <= '0;
               rel[i]  <= 1'b1;
            end else if (st[i] == IDLE) begin
               if (rise[i]) begin
                  st[i]   <= HELD;
                  hold[i] <= '0;
                  prs[i]  <= 1'b1;
               end
            end else if (st[i] == HELD) begin
               hold[i] <= hold[i] + 27'd1;
               if (hold[i] == LONG_MAX) begin
                  st[i]  <= LONG;
                  lng[i] <= 1'b1;
                  rpt[i] <= '0;
               end
            end else if (RPT_MASK[i]) begin
               rpt[i] <= (rpt[i] == RPT_MAX) ? '0 : rpt[i] + 27'd1;
               prs[i] <= rpt[i] == RPT_MAX;
            end
         end
   assign kb.o_level   = lvl;
   assign kb.o_press   = prs;
   assign kb.o_release = rel;
   assign kb.o_long    = lng;
endmodule

// File: tb/tb_key_cond.sv
// tb_key_cond: randomized and directed checks of key_cond against a behavioural event model
module tb_key_cond;
   localparam int DEB = 4;
   localparam int LONG = 20;
   localparam int RPT = 5;
   localparam logic [3:0] MASK = 4'b0100;
   logic clk = 1'b0;
   logic rst = 1'b1;
   key_cond_if kb ();
   key_cond #(.DEB_CYC(DEB), .LONG_CYC(LONG), .RPT_CYC(RPT), .RPT_MASK(MASK)) dut (
      .clk(clk),
      .rst(rst),
      .kb(kb)
   );
   int passed = 0;
   int total = 0;
   int n, tch, lv;
   int pq[$], lq[$], rq[$];
   logic [3:0] h1, h2, ml, lastp, e_prs, e_rel, e_lng;
   int run [4];
   int age [4];
   // free-running clock
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n, got, exp);
      else passed++;
   endtask
   // reference: a level flips once p has disagreed for DEB straight edges; events follow from press age
   task automatic model_step(input logic [3:0] sw, input logic r);
      logic [3:0] p;
      e_prs = '0;
      e_rel = '0;
      e_lng = '0;
      if (r) begin
         h1 = 4'hf;
         h2 = 4'hf;
         ml = '0;
         lastp = '0;
         for (int i = 0; i < 4; i++) begin
            run[i] = 0;
            age[i] = 0;
         end
      end else begin
         p = ~h2;
         h2 = h1;
         h1 = sw;
         for (int i = 0; i < 4; i++) begin
            run[i] = (p[i] == lastp[i]) ? run[i] + 1 : 1;
            lastp[i] = p[i];
            if (p[i] != ml[i] && run[i] >= DEB) begin
               ml[i] = p[i];
               if (p[i]) begin
                  age[i] = 0;
                  e_prs[i] = 1'b1;
               end else e_rel[i] = 1'b1;
            end else if (ml[i]) begin
               age[i]++;
               e_lng[i] = age[i] == LONG;
               e_prs[i] = MASK[i] && age[i] > LONG && (age[i] - LONG) % RPT == 0;
            end
         end
      end
   endtask
   task automatic run_cycle(input logic [3:0] sw, input logic r);
      kb.i_sw = sw;
      rst = r;
      @(posedge clk);
      model_step(sw, r);
      #1;
      n++;
      chk("level", kb.o_level, ml);
      chk("press", kb.o_press, e_prs);
      chk("release", kb.o_release, e_rel);
      chk("long", kb.o_long, e_lng);
      if (kb.o_press[tch]) pq.push_back(n);
      if (kb.o_long[tch]) lq.push_back(n);
      if (kb.o_release[tch]) rq.push_back(n);
      if (kb.o_level[tch]) lv++;
   endtask
   task automatic start(input int ch);
      tch = ch;
      for (int i = 0; i < 3; i++) run_cycle(4'hf, 1'b1);
      n = 0;
      lv = 0;
      pq.delete();
      lq.delete();
      rq.delete();
   endtask
   // directed scenarios, then randomized traffic with occasional resets
   initial begin
      logic [3:0] sw;
      logic r;
      kb.i_sw = 4'hf;
      n = 0;
      tch = 0;
      start(0);
      for (int e = 0; e < 46; e++) run_cycle(e >= 10 ? 4'b1110 : 4'hf, 1'b0);
      chk("A.npress", pq.size(), 1);
      chk("A.press0", pq[0], 16);
      chk("A.nlong", lq.size(), 1);
      chk("A.long0", lq[0], 36);
      chk("A.nrel", rq.size(), 0);
      start(2);
      for (int e = 0; e < 71; e++) run_cycle((e >= 10 && e < 60) ? 4'b1011 : 4'hf, 1'b0);
      chk("B.npress", pq.size(), 6);
      for (int k = 0; k < 6; k++) chk($sformatf("B.press%0d", k), pq[k], k == 0 ? 16 : 36 + 5 * k);
      chk("B.nlong", lq.size(), 1);
      chk("B.long0", lq[0], 36);
      chk("B.nrel", rq.size(), 1);
      chk("B.rel0", rq[0], 66);
      start(1);
      for (int e = 0; e < 80; e++) run_cycle((e >= 10 && e < 70 && (e - 10) % 6 < 3) ? 4'b1101 : 4'hf, 1'b0);
      chk("C.npress", pq.size(), 0);
      chk("C.nrel", rq.size(), 0);
      chk("C.nlong", lq.size(), 0);
      chk("C.level", lv, 0);
      start(3);
      for (int e = 0; e < 46; e++) run_cycle((e >= 10 && e < 30) ? 4'b0000 : 4'hf, 1'b0);
      chk("D.npress", pq.size(), 1);
      chk("D.press0", pq[0], 16);
      chk("D.nrel", rq.size(), 1);
      chk("D.rel0", rq[0], 36);
      chk("D.nlong", lq.size(), 0);
      start(0);
      for (int e = 0; e < 46; e++) run_cycle(e >= 10 ? 4'b1110 : 4'hf, e >= 24 && e < 27);
      chk("E.npress", pq.size(), 2);
      chk("E.press0", pq[0], 16);
      chk("E.press1", pq[1], 33);
      chk("E.nrel", rq.size(), 0);
      chk("E.nlong", lq.size(), 0);
      start(2);
      sw = 4'hf;
      for (int e = 0; e < 4000; e++) begin
         for (int i = 0; i < 4; i++) if ($urandom_range(0, 29) == 0) sw[i] = ~sw[i];
         r = $urandom_range(0, 399) == 0;
         run_cycle(sw, r);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/key_cond.md
KEY_COND -- requirements
Module: key_cond

Interface
REQ-001 Parameter DEB_CYC, default 500000, debounce window in clk cycles (10 ms at 50 MHz); legal range 2..2^24-1.
REQ-002 Parameter LONG_CYC, default 50000000, hold time in clk cycles before long-press (1 s); legal range 2..2^27-1, SHALL exceed DEB_CYC.
REQ-003 Parameter RPT_CYC, default 10000000, auto-repeat period in clk cycles (200 ms); legal range 2..2^27-1.
REQ-004 Parameter RPT_MASK, default 4'b0100, per-channel auto-repeat enable.
REQ-005 clk  input  1  single system clock, all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 i_sw  input  4  raw push-buttons, asynchronous, active-low (0 = pressed).
REQ-008 o_level  output  4  debounced pressed level, 1 = pressed.
REQ-009 o_press  output  4  one-cycle pulse per debounced press and per auto-repeat step.
REQ-010 o_release  output  4  one-cycle pulse per debounced release.
REQ-011 o_long  output  4  one-cycle pulse when a press has been held LONG_CYC cycles.

Function
REQ-012 The four channels SHALL be independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-013 Each i_sw bit SHALL pass a 2-flop synchronizer; p = inverted synchronizer output (1 = pressed).
REQ-014 Debounce counter: increments each cycle p != o_level; clears when p == o_level.
REQ-015 When the debounce counter reaches DEB_CYC-1 with p != o_level, o_level SHALL toggle on the next edge and the counter SHALL clear.
REQ-016 Latency: a clean press first sampled at edge k SHALL assert o_level and o_press at edge k+2+DEB_CYC; release is symmetric with o_release.
REQ-017 Any p disturbance shorter than DEB_CYC consecutive cycles SHALL produce no change on any output.
REQ-018 Per-channel FSM states: IDLE (o_level=0), HELD (o_level=1, before long), LONG (o_level=1, after long).
REQ-019 IDLE->HELD on debounced press; hold counter clears to 0 in that cycle.
REQ-020 In HELD the hold counter SHALL increment each cycle; o_long SHALL pulse and state SHALL become LONG exactly LONG_CYC cycles after the o_press pulse.
REQ-021 In LONG with RPT_MASK bit set, o_press SHALL pulse every RPT_CYC cycles, the first RPT_CYC cycles after o_long; with the bit clear, no further pulses.
REQ-022 HELD or LONG -> IDLE on debounced release; o_release pulses, hold and repeat counters clear, pending long/repeat pulses are cancelled.
REQ-023 o_long SHALL pulse at most once per press; counters SHALL not wrap while held (repeat counter reloads, hold counter stops in LONG).
REQ-024 o_press and o_release SHALL never be high together on one channel; o_press and o_long SHALL never coincide.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 While rst=1: synchronizer flops = 1 (released), o_level=0, o_press=o_release=o_long=0, all counters 0, all FSMs IDLE.
REQ-027 Reset asserted mid-hold SHALL abort without o_release; a button still held after rst falls SHALL be treated as a new press (o_press at 2+DEB_CYC cycles after rst deasserts).

Verification (DEB_CYC=4, LONG_CYC=20, RPT_CYC=5, RPT_MASK=4'b0100)
REQ-028 i_sw[0] low from edge 10, held -> o_level[0]=1 and o_press[0] pulse at edge 16; o_long[0] pulse at edge 36; no further o_press[0].
REQ-029 i_sw[2] low from edge 10, held to edge 60 -> o_press[2] at 16, o_long[2] at 36, o_press[2] at 41, 46, 51, 56, 61; i_sw[2] high at 60 -> o_release[2] at 66, no press at 66.
REQ-030 i_sw[1] low for 3 cycles, then high, repeated 10 times -> all outputs for channel 1 remain 0.
REQ-031 i_sw[3:0] all low at edge 10 -> o_press=4'b1111 single pulse at edge 16; all high at edge 30 -> o_release=4'b1111 at edge 36, no o_long.
REQ-032 i_sw[0] held, rst=1 for edges 25-27 -> all outputs 0 during reset, no o_release; new o_press[0] at 2+4 cycles after rst falls.
